// File: rtl/systolic_operand_loader_if.sv
// Buffer write port for the systolic operand loader: valid/ready with A/B select.
interface systolic_operand_loader_if #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned ADDR_W = 5
);
    logic              wr_valid;
    logic              wr_ready;
    logic              wr_sel;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;

    modport master (
        output wr_valid,
        output wr_sel,
        output wr_addr,
        output wr_data,
        input  wr_ready
    );

    modport slave (
        input  wr_valid,
        input  wr_sel,
        input  wr_addr,
        input  wr_data,
        output wr_ready
    );
endinterface

// File: rtl/systolic_operand_loader.sv
// Upstream feeder for the systolic array: buffers A/B vectors, then sequences one
// array pass (clear, enable until the array's sticky ready, done) with a watchdog.
module systolic_operand_loader #(
    parameter  int unsigned DATA_W  = 16,
    parameter  int unsigned MAX_N   = 32,
    parameter  int unsigned TMO_CYC = 72,
    localparam int unsigned N_W     = $clog2(MAX_N + 1),
    localparam int unsigned WD_W    = $clog2(TMO_CYC + 1)
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [N_W-1:0]                 matrix_N,
    input  logic                           start,
    systolic_operand_loader_if.slave       wr,
    output logic [MAX_N-1:0][DATA_W-1:0]   arr_a,
    output logic [MAX_N-1:0][DATA_W-1:0]   arr_b,
    output logic                           arr_en,
    output logic                           arr_clr,
    input  logic                           arr_ready,
    output logic                           busy,
    output logic                           done,
    output logic                           err
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_CLEAR = 3'd1;
    localparam logic [2:0] S_RUN   = 3'd2;
    localparam logic [2:0] S_DONE  = 3'd3;
    localparam logic [2:0] S_ERR   = 3'd4;

    logic [2:0]                  state, state_next;
    logic [WD_W-1:0]             wdog, wdog_next;
    logic [N_W-1:0]              n_lat, n_next;
    logic [MAX_N-1:0][DATA_W-1:0] buf_a, buf_b, a_next, b_next;
    logic [MAX_N-1:0][DATA_W-1:0] arr_a_next, arr_b_next;
    logic                        wr_ready_q;
    logic                        wr_fire;
    logic                        n_legal;
    logic                        start_bad;

    assign wr.wr_ready = wr_ready_q;

    // Next state, watchdog, latched size and buffer contents
    always_comb begin
        state_next = state;
        wdog_next  = wdog;
        n_next     = n_lat;
        a_next     = buf_a;
        b_next     = buf_b;
        wr_fire    = wr.wr_valid && (state == S_IDLE);
        n_legal    = (matrix_N != '0) && (matrix_N <= N_W'(MAX_N));
        start_bad  = (state == S_IDLE) && start && !n_legal;

        // A write on the start edge commits before the pass begins
        if (wr_fire) begin
            if (wr.wr_sel) begin
                b_next[wr.wr_addr] = wr.wr_data;
            end else begin
                a_next[wr.wr_addr] = wr.wr_data;
            end
        end

        case (state)
            S_IDLE: begin
                if (start && n_legal) begin
                    n_next     = matrix_N;
                    state_next = S_CLEAR;
                end
            end
            S_CLEAR: begin
                wdog_next  = '0;
                state_next = S_RUN;
            end
            S_RUN: begin
                wdog_next = wdog + WD_W'(1);
                if (arr_ready) begin
                    state_next = S_DONE;
                end else if (wdog == WD_W'(TMO_CYC - 1)) begin
                    state_next = S_ERR;
                end
            end
            S_DONE:  state_next = S_IDLE;
            S_ERR:   state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // Lanes at or beyond the latched size are presented as zero
    always_comb begin
        arr_a_next = '0;
        arr_b_next = '0;
        for (int unsigned i = 0; i < MAX_N; i++) begin
            if (N_W'(i) < n_next) begin
                arr_a_next[i] = a_next[i];
                arr_b_next[i] = b_next[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_IDLE;
            wdog       <= '0;
            n_lat      <= '0;
            buf_a      <= '0;
            buf_b      <= '0;
            arr_a      <= '0;
            arr_b      <= '0;
            arr_en     <= 1'b0;
            arr_clr    <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
            wr_ready_q <= 1'b1;
        end else begin
            state      <= state_next;
            wdog       <= wdog_next;
            n_lat      <= n_next;
            buf_a      <= a_next;
            buf_b      <= b_next;
            arr_a      <= arr_a_next;
            arr_b      <= arr_b_next;
            arr_en     <= (state_next == S_RUN);
            arr_clr    <= (state_next == S_CLEAR);
            busy       <= (state_next != S_IDLE);
            done       <= (state_next == S_DONE);
            err        <= (state_next == S_ERR) || start_bad;
            wr_ready_q <= (state_next == S_IDLE);
        end
    end

endmodule
